// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the HyperBus burst controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
`timescale 1ns/1ps
package hyperbus_pkg;

  // One-hot controller states; any other encoding is treated as illegal.
  typedef enum logic [7:0] {
    ST_RESET   = 8'b0000_0001,
    ST_IDLE    = 8'b0000_0010,
    ST_CMD     = 8'b0000_0100,
    ST_LATENCY = 8'b0000_1000,
    ST_READ    = 8'b0001_0000,
    ST_WRITE   = 8'b0010_0000,
    ST_RECOVER = 8'b0100_0000,
    ST_ERROR   = 8'b1000_0000
  } state_t;

  // Command/address word layout.
  localparam int CA_W         = 48;
  localparam int CA_RW_BIT    = 47;  // 1 = read
  localparam int CA_AS_BIT    = 46;  // 1 = register space
  localparam int CA_BURST_BIT = 45;  // 1 = linear burst
  localparam int CA_ROW_HI    = 44;
  localparam int CA_ROW_LO    = 16;
  localparam int CA_COL_HI    = 2;
  localparam int CA_COL_LO    = 0;

  // RWDS pattern marking a valid read word on the single-rate PHY view.
  localparam logic [1:0] RWDS_STROBE = 2'b01;

  function automatic logic [CA_W-1:0] ca_pack(input logic        write,
                                              input logic        reg_space,
                                              input logic [31:0] adr);
    logic [CA_W-1:0] ca;
    ca                          = '0;
    ca[CA_RW_BIT]               = ~write;
    ca[CA_AS_BIT]               = reg_space;
    ca[CA_BURST_BIT]            = 1'b1;
    ca[CA_ROW_HI:CA_ROW_LO]     = adr[31:3];
    ca[CA_COL_HI:CA_COL_LO]     = adr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hyperbus_ca_shift.sv
// Command/address shifter: loads a 48-bit CA word and presents it 16 bits at a time, MSW first.
// Latency: loaded word visible the cycle after load; each shift advances one 16-bit word.
// Backpressure: none; shifts whenever the controller asks.
// Ports: clk90/rst clock and async reset; load + ca_in capture a new CA word;
//        shift advances to the next word; word is the 16-bit word currently on top.
`timescale 1ns/1ps
module hyperbus_ca_shift
  import hyperbus_pkg::*;
(
  input  logic            clk90,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [CA_W-1:0] ca_in,
  output logic [15:0]     word
);

  logic [CA_W-1:0] sr;

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= ca_in;
    end else if (shift) begin
      sr <= {sr[CA_W-17:0], 16'h0000};
    end
  end

  assign word = sr[CA_W-1 -: 16];

endmodule

// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus primary controller: linear read/write bursts, masked writes, register writes, read timeout.
// Latency: CA on DQ the cycle after request accept; data phase after 3 CA + TACC (or 2*TACC) cycles; read data strobe+1.
// Backpressure: req_ready only in IDLE; wr_ready asserted every WRITE cycle, a missing wr_valid sends a fully masked word.
// Ports: req_* request channel; wr_* write data channel; rd_* read data; busy/error_o/clear_error status;
//        phy_* single-rate (two bytes per cycle) view of the DDR pads, which live in the parent.
`timescale 1ns/1ps
module hyperbus_burst_ctrl
  import hyperbus_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int TACC_COUNT    = 6,
  parameter int RESET_COUNT   = 2,
  parameter int MAX_BURST     = 16,
  parameter int TIMEOUT       = 31,
  parameter int CSN_IDLE      = 2,
  parameter int FIXED_LATENCY = 0,
  localparam int LW = $clog2(MAX_BURST + 1),
  localparam int DW = 2 * WIDTH
)(
  input  logic          clk90,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_reg_space,
  input  logic [31:0]   req_adr,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_strb,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  output logic          busy,
  output logic          error_o,
  input  logic          clear_error,
  output logic          phy_rstn,
  output logic          phy_csn,
  output logic          phy_ck_en,
  output logic [DW-1:0] phy_dq_o,
  output logic          phy_dq_oe,
  input  logic [DW-1:0] phy_dq_i,
  output logic [1:0]    phy_rwds_o,
  output logic          phy_rwds_oe,
  input  logic [1:0]    phy_rwds_i
);

  // One shared down-counter serves reset hold, CA cycles, latency and CS# recovery.
  localparam int CW = $clog2(2 * TACC_COUNT + RESET_COUNT + CSN_IDLE + 4);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [LW-1:0] rem, rem_d;       // words still to transfer, including the current one
  logic [TW-1:0] tmo, tmo_d;
  logic          two_x, two_x_d;
  logic          write_q, write_d;
  logic          reg_q, reg_d;

  logic          ca_load;
  logic          ca_shift_en;
  logic [15:0]   ca_word;
  logic          strobe;

  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          rd_last_q;

  assign ca_load     = (state == ST_IDLE) && req_valid;
  assign ca_shift_en = (state == ST_CMD);
  assign strobe      = (state == ST_READ) && (phy_rwds_i == RWDS_STROBE);

  hyperbus_ca_shift u_ca_shift (
    .clk90 (clk90),
    .rst   (rst),
    .load  (ca_load),
    .shift (ca_shift_en),
    .ca_in (ca_pack(req_write, req_reg_space, req_adr)),
    .word  (ca_word)
  );

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      state   <= ST_RESET;
      cnt     <= CW'(RESET_COUNT);
      rem     <= '0;
      tmo     <= '0;
      two_x   <= 1'b0;
      write_q <= 1'b0;
      reg_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rem     <= rem_d;
      tmo     <= tmo_d;
      two_x   <= two_x_d;
      write_q <= write_d;
      reg_q   <= reg_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rem_d       = rem;
    tmo_d       = tmo;
    two_x_d     = two_x;
    write_d     = write_q;
    reg_d       = reg_q;
    phy_rstn    = 1'b1;
    phy_csn     = 1'b1;
    phy_ck_en   = 1'b0;
    phy_dq_o    = '0;
    phy_dq_oe   = 1'b0;
    phy_rwds_o  = 2'b00;
    phy_rwds_oe = 1'b0;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    error_o     = 1'b0;

    case (state)
      ST_RESET: begin
        phy_rstn = 1'b0;
        if (cnt == '0) state_d = ST_IDLE;
        else           cnt_d   = cnt - CW'(1);
      end

      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ST_CMD;
          cnt_d   = CW'(2);
          write_d = req_write;
          reg_d   = req_reg_space;
          rem_d   = (req_len == '0) ? LW'(1) : req_len;
        end
      end

      ST_CMD: begin
        phy_csn   = 1'b0;
        phy_ck_en = 1'b1;
        phy_dq_oe = 1'b1;
        phy_dq_o  = DW'(ca_word);
        // The memory signals 2x latency on RWDS only during the first CA word.
        if (cnt == CW'(2)) two_x_d = (FIXED_LATENCY != 0) || (phy_rwds_i != 2'b00);
        if (cnt == '0) begin
          if (write_q && reg_q) begin
            // Register writes have zero latency and are always a single word.
            state_d = ST_WRITE;
            rem_d   = LW'(1);
          end else begin
            state_d = ST_LATENCY;
            cnt_d   = two_x ? CW'(2 * TACC_COUNT - 1) : CW'(TACC_COUNT - 1);
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      ST_LATENCY: begin
        phy_csn   = 1'b0;
        phy_ck_en = 1'b1;
        if (cnt == '0) begin
          state_d = write_q ? ST_WRITE : ST_READ;
          tmo_d   = TW'(TIMEOUT);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      ST_WRITE: begin
        phy_csn     = 1'b0;
        phy_ck_en   = 1'b1;
        phy_dq_oe   = 1'b1;
        phy_rwds_oe = ~reg_q;
        wr_ready    = 1'b1;
        if (wr_valid) begin
          phy_dq_o   = wr_data;
          phy_rwds_o = ~wr_strb;
        end else begin
          // No data this cycle: the word slot is still spent, with both bytes masked.
          phy_rwds_o = 2'b11;
        end
        if (rem == LW'(1)) begin
          state_d = ST_RECOVER;
          cnt_d   = CW'(CSN_IDLE - 1);
        end else begin
          rem_d = rem - LW'(1);
        end
      end

      ST_READ: begin
        phy_csn   = 1'b0;
        phy_ck_en = 1'b1;
        // A strobe in the same cycle the timeout expires still counts as a word.
        if (strobe) begin
          tmo_d = TW'(TIMEOUT);
          if (rem == LW'(1)) begin
            state_d = ST_RECOVER;
            cnt_d   = CW'(CSN_IDLE - 1);
          end else begin
            rem_d = rem - LW'(1);
          end
        end else if (tmo == '0) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo - TW'(1);
        end
      end

      ST_RECOVER: begin
        if (cnt == '0) state_d = ST_IDLE;
        else           cnt_d   = cnt - CW'(1);
      end

      ST_ERROR: begin
        error_o = 1'b1;
        if (clear_error) begin
          state_d = ST_RECOVER;
          cnt_d   = CW'(CSN_IDLE - 1);
        end
      end

      default: begin
        phy_rstn = 1'b0;
        state_d  = ST_RESET;
        cnt_d    = CW'(RESET_COUNT);
      end
    endcase
  end

  // Read data is captured on the strobe cycle and presented one cycle later.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= strobe;
      rd_last_q  <= strobe && (rem == LW'(1));
      if (strobe) rd_data_q <= phy_dq_i;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
`timescale 1ns/1ps
module tb_hyperbus_burst_ctrl;

  localparam int LW = $clog2(16 + 1);

  logic          clk90 = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_reg_space;
  logic [31:0]   req_adr;
  logic [LW-1:0] req_len;
  logic [15:0]   wr_data;
  logic [1:0]    wr_strb;
  logic          wr_valid, wr_ready;
  logic [15:0]   rd_data;
  logic          rd_valid, rd_last, busy, error_o, clear_error;
  logic          phy_rstn, phy_csn, phy_ck_en;
  logic [15:0]   phy_dq_o, phy_dq_i;
  logic          phy_dq_oe;
  logic [1:0]    phy_rwds_o, phy_rwds_i;
  logic          phy_rwds_oe;

  hyperbus_burst_ctrl #(
    .WIDTH(8), .TACC_COUNT(6), .RESET_COUNT(2), .MAX_BURST(16),
    .TIMEOUT(31), .CSN_IDLE(2), .FIXED_LATENCY(0)
  ) dut (
    .clk90(clk90), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg_space(req_reg_space), .req_adr(req_adr), .req_len(req_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .error_o(error_o), .clear_error(clear_error),
    .phy_rstn(phy_rstn), .phy_csn(phy_csn), .phy_ck_en(phy_ck_en),
    .phy_dq_o(phy_dq_o), .phy_dq_oe(phy_dq_oe), .phy_dq_i(phy_dq_i),
    .phy_rwds_o(phy_rwds_o), .phy_rwds_oe(phy_rwds_oe), .phy_rwds_i(phy_rwds_i)
  );

  always #5 clk90 = ~clk90;

  // cyc numbers the interval following each rising edge.
  int cyc = 0;
  always @(posedge clk90) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] cyc; logic [15:0] dq; logic dq_care; logic roe; logic [1:0] rwds; logic rwds_care;
  } pw_t;
  typedef struct packed { logic [31:0] cyc; logic [15:0] dat; logic last; } rd_t;
  typedef struct packed { logic [31:0] cyc; logic [10:0] val; logic [10:0] mask; } st_t;

  pw_t pw_q[$];
  rd_t rd_q[$];
  st_t st_q[$];
  pw_t pe;
  rd_t re;
  st_t se;

  // Status bits: rstn csn ck_en req_ready busy error wr_ready rd_valid rd_last dq_oe rwds_oe
  logic [10:0] st_now;
  assign st_now = {phy_rstn, phy_csn, phy_ck_en, req_ready, busy, error_o,
                   wr_ready, rd_valid, rd_last, phy_dq_oe, phy_rwds_oe};

  localparam logic [10:0] S_RST  = 11'b01001000000;
  localparam logic [10:0] S_IDLE = 11'b11010000000;
  localparam logic [10:0] S_LAT  = 11'b10101000000;
  localparam logic [10:0] S_RD   = 11'b10101000000;
  localparam logic [10:0] S_WR   = 11'b10101010011;
  localparam logic [10:0] S_RWR  = 11'b10101010010;
  localparam logic [10:0] S_REC  = 11'b11001000000;
  localparam logic [10:0] S_ERR  = 11'b11001100000;
  localparam logic [10:0] M_ALL  = 11'b11111111111;
  localparam logic [10:0] M_NRD  = 11'b11111110011;
  localparam logic [10:0] M_ERR  = 11'b11011110011;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk90) begin
    if (phy_dq_oe) begin
      checks++;
      if (pw_q.size() == 0) begin
        errors++;
        $display("FAIL phy_word unexpected cyc=%0d dq=%h rwds_oe=%b rwds=%b", cyc, phy_dq_o, phy_rwds_oe, phy_rwds_o);
      end else begin
        pe = pw_q.pop_front();
        if (pe.cyc != 32'(cyc) || (pe.dq_care && phy_dq_o != pe.dq) || phy_rwds_oe != pe.roe ||
            (pe.rwds_care && phy_rwds_o != pe.rwds)) begin
          errors++;
          $display("FAIL phy_word cyc=%0d dq=%h rwds_oe=%b rwds=%b, expected cyc=%0d dq=%h rwds_oe=%b rwds=%b",
                   cyc, phy_dq_o, phy_rwds_oe, phy_rwds_o, pe.cyc, pe.dq, pe.roe, pe.rwds);
        end
      end
    end
    if (rd_valid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_word unexpected cyc=%0d data=%h last=%b", cyc, rd_data, rd_last);
      end else begin
        re = rd_q.pop_front();
        if (re.cyc != 32'(cyc) || rd_data != re.dat || rd_last != re.last) begin
          errors++;
          $display("FAIL rd_word cyc=%0d data=%h last=%b, expected cyc=%0d data=%h last=%b",
                   cyc, rd_data, rd_last, re.cyc, re.dat, re.last);
        end
      end
    end
    while (st_q.size() != 0 && st_q[0].cyc <= 32'(cyc)) begin
      se = st_q.pop_front();
      checks++;
      if (se.cyc != 32'(cyc) || ((st_now ^ se.val) & se.mask) != 11'b0) begin
        errors++;
        $display("FAIL status cyc=%0d got=%b expected=%b mask=%b (for cyc %0d)", cyc, st_now, se.val, se.mask, se.cyc);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk90);
      #1;
    end
  endtask

  task automatic push_pw(input int c, input logic [15:0] dq, input logic dqc,
                         input logic roe, input logic [1:0] rw, input logic rwc);
    pw_q.push_back({32'(c), dq, dqc, roe, rw, rwc});
  endtask

  task automatic push_rd(input int c, input logic [15:0] dat, input logic last);
    rd_q.push_back({32'(c), dat, last});
  endtask

  task automatic push_st(input int c, input logic [10:0] v, input logic [10:0] m);
    st_q.push_back({32'(c), v, m});
  endtask

  task automatic issue(input logic wr, input logic rg, input logic [31:0] adr, input logic [LW-1:0] len);
    req_valid     = 1'b1;
    req_write     = wr;
    req_reg_space = rg;
    req_adr       = adr;
    req_len       = len;
    @(posedge clk90);
    #1;
    req_valid = 1'b0;
  endtask

  logic [15:0] rdat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  int          rofs [4] = '{0, 2, 3, 5};

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_reg_space = 1'b0; req_adr = '0; req_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0; clear_error = 1'b0;
    phy_dq_i = '0; phy_rwds_i = '0;

    // Reset: held for 3 cycles, then phy_rstn low for RESET_COUNT+1 cycles.
    push_st(1, S_RST, M_ALL);
    push_st(2, S_RST, M_ALL);
    push_st(3, S_RST, M_ALL);
    push_st(5, S_RST, M_ALL);
    push_st(6, S_IDLE, M_NRD);
    goto(3);
    rst = 1'b0;

    // 1x read, 4 words at 0x10; data phase at 8+4+6 = 18.
    goto(8);
    push_pw(9,  16'hA000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(10, 16'h0002, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(11, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_st(12, S_LAT, M_NRD);
    for (int i = 0; i < 4; i++) push_rd(19 + rofs[i], rdat[i], i == 3);
    push_st(25, S_REC, M_NRD);
    push_st(26, S_IDLE, M_NRD);
    issue(1'b0, 1'b0, 32'h0000_0010, LW'(4));
    for (int i = 0; i < 4; i++) begin
      goto(18 + rofs[i]);
      phy_rwds_i = 2'b01;
      phy_dq_i   = rdat[i];
      @(posedge clk90);
      #1;
      phy_rwds_i = 2'b00;
    end

    // 2x write, 2 words at 0x1235; 12 latency cycles, data at 28+4+12 = 44.
    goto(28);
    push_pw(29, 16'h2000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(30, 16'h0246, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(31, 16'h0005, 1'b1, 1'b0, 2'b00, 1'b0);
    push_st(43, S_LAT, M_NRD);
    push_st(44, S_WR, M_NRD);
    push_pw(44, 16'hABCD, 1'b1, 1'b1, 2'b01, 1'b1);
    push_pw(45, 16'h0000, 1'b0, 1'b1, 2'b11, 1'b1);
    push_st(46, S_REC, M_NRD);
    push_st(48, S_IDLE, M_NRD);
    issue(1'b1, 1'b0, 32'h0000_1235, LW'(2));
    phy_rwds_i = 2'b11;
    goto(30);
    phy_rwds_i = 2'b00;
    goto(44);
    wr_valid = 1'b1; wr_data = 16'hABCD; wr_strb = 2'b10;
    goto(45);
    wr_valid = 1'b0; wr_data = 16'h5555; wr_strb = 2'b11;
    goto(46);

    // Register write: zero latency, length forced to one word, RWDS not driven.
    goto(50);
    push_pw(51, 16'h6000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(52, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(53, 16'h0001, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(54, 16'h8F1F, 1'b1, 1'b0, 2'b00, 1'b0);
    push_st(54, S_RWR, M_NRD);
    push_st(55, S_REC, M_NRD);
    push_st(57, S_IDLE, M_NRD);
    issue(1'b1, 1'b1, 32'h0000_0001, LW'(3));
    goto(54);
    wr_valid = 1'b1; wr_data = 16'h8F1F; wr_strb = 2'b11;
    goto(55);
    wr_valid = 1'b0;

    // Read timeout: READ from 70, 32 strobe-less cycles, ERROR at 102.
    goto(60);
    push_pw(61, 16'hA000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(62, 16'h0004, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(63, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_st(101, S_RD, M_ALL);
    push_st(102, S_ERR, M_ERR);
    push_st(104, S_ERR, M_ERR);
    push_st(105, S_REC, M_NRD);
    push_st(106, S_REC, M_NRD);
    push_st(107, S_IDLE, M_NRD);
    issue(1'b0, 1'b0, 32'h0000_0020, LW'(2));
    goto(104);
    clear_error = 1'b1;
    goto(105);
    clear_error = 1'b0;

    // Reset during the second read word: everything returns to reset values at once.
    goto(110);
    push_pw(111, 16'hA000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(112, 16'h0002, 1'b1, 1'b0, 2'b00, 1'b0);
    push_pw(113, 16'h0000, 1'b1, 1'b0, 2'b00, 1'b0);
    push_st(120, S_RD, M_ALL);
    push_st(121, S_RST, M_ALL);
    push_st(122, S_RST, M_ALL);
    push_st(126, S_RST, M_ALL);
    push_st(127, S_IDLE, M_NRD);
    issue(1'b0, 1'b0, 32'h0000_0010, LW'(4));
    goto(120);
    phy_rwds_i = 2'b01; phy_dq_i = 16'h7777;
    goto(121);
    phy_dq_i = 16'h8888;
    #2;
    rst = 1'b1;
    phy_rwds_i = 2'b00;
    goto(124);
    rst = 1'b0;

    goto(130);
    checks++;
    if (pw_q.size() != 0) begin
      errors++;
      $display("FAIL phy_word_leftover remaining=%0d expected 0", pw_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_word_leftover remaining=%0d expected 0", rd_q.size());
    end
    checks++;
    if (st_q.size() != 0) begin
      errors++;
      $display("FAIL status_leftover remaining=%0d expected 0", st_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyperbus_burst_ctrl.md
# hyperbus_burst_ctrl

Second-generation HyperBus primary controller. Adds variable-length linear bursts for reads and writes, byte-masked writes, zero-latency register writes, and forced fixed latency. Also adds a per-word read timeout with a clearable error state. It sits between the user request port and the existing `ioddr` instances, which remain in the parent. All PHY-side signals here are single-rate words, two bytes per cycle.

## Interface
- `WIDTH`, 8: DQ bus width; user data words are 2*WIDTH.
- `TACC_COUNT`, 6: initial-latency cycles at 1x latency.
- `RESET_COUNT`, 2: cycles `phy_rstn` is held low after reset.
- `MAX_BURST`, 16: maximum words per request. LW = $clog2(MAX_BURST+1).
- `TIMEOUT`, 31: maximum cycles between read strobes.
- `CSN_IDLE`, 2: minimum CS# high cycles between transactions.
- `FIXED_LATENCY`, 0: 1 forces 2x latency regardless of RWDS.
- `clk90` in 1: clock, memory clock shifted 90°; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` / `req_ready` in/out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_reg_space` in 1: 1 = register space.
- `req_adr` in 32: word address.
- `req_len` in LW: words in the burst; 0 is treated as 1.
- `wr_data` in 2*WIDTH: write word.
- `wr_strb` in 2: byte enables, active-high.
- `wr_valid` / `wr_ready` in/out 1: write data handshake.
- `rd_data` out 2*WIDTH: read word.
- `rd_valid` out 1: read word strobe.
- `rd_last` out 1: marks the final read word.
- `busy` out 1: high whenever state is not IDLE.
- `error_o` out 1: high in ERROR.
- `clear_error` in 1: one-cycle pulse that leaves ERROR.
- `phy_rstn`, `phy_csn`, `phy_ck_en` out 1: memory reset, chip select, clock gate enable.
- `phy_dq_o` out 2*WIDTH, `phy_dq_oe` out 1, `phy_dq_i` in 2*WIDTH: DQ path.
- `phy_rwds_o` out 2, `phy_rwds_oe` out 1, `phy_rwds_i` in 2: RWDS path.

## Operation
- **States:** RESET, IDLE, CMD, LATENCY, READ, WRITE, RECOVER, ERROR. One-hot; any illegal encoding goes to RESET.
- **Reset values:**
  - State RESET, counter = RESET_COUNT.
  - `phy_rstn`=0, `phy_csn`=1, `phy_ck_en`=0, `phy_dq_oe`=0, `phy_rwds_oe`=0.
  - `req_ready`=0, `wr_ready`=0, `rd_valid`=0, `rd_last`=0.
  - `busy`=1, `error_o`=0.
- **Reset mid-transaction:** all outputs take their reset values immediately.
- **RESET:** count down; at 0 go to IDLE.
- **IDLE:** `req_ready`=1. On `req_valid`, latch the CA register, length and direction, then go to CMD.
- **CA word** (48 bits):
  - [47] = ~`req_write`
  - [46] = `req_reg_space`
  - [45] = 1 (linear burst)
  - [44:16] = `req_adr`[31:3]
  - [15:3] = 0
  - [2:0] = `req_adr`[2:0]
- **CMD:** three cycles, driving `phy_dq_o` = CA[47:32], then CA[31:16], then CA[15:0]. `phy_dq_oe`=1, `phy_csn`=0, `phy_ck_en`=1.
  - Sample `phy_rwds_i`!=0 in the first CMD cycle to select 2x latency. FIXED_LATENCY=1 always selects 2x.
  - Register-space write: go straight to WRITE with length forced to 1.
  - Otherwise: go to LATENCY.
- **LATENCY:** run TACC_COUNT cycles (2*TACC_COUNT for 2x) with `phy_dq_oe`=0, then go to READ or WRITE.
- **WRITE:**
  - `phy_dq_oe`=1, `phy_rwds_oe`=1 (0 for register writes), `wr_ready`=1.
  - With `wr_valid`: `phy_dq_o` = `wr_data`, `phy_rwds_o` = ~`wr_strb`.
  - Without `wr_valid`: `phy_rwds_o` = 2'b11 (both bytes masked, word still consumed).
  - After len words go to RECOVER.
- **READ:**
  - A cycle with `phy_rwds_i` == 2'b01 is a valid word.
  - `rd_data` is registered from `phy_dq_i`; `rd_valid` pulses on the next cycle; `rd_last` is asserted with word len.
  - After word len go to RECOVER.
  - The timeout counter reloads on every valid word. If it reaches 0, go to ERROR.
- **RECOVER:** `phy_csn`=1, `phy_ck_en`=0 for CSN_IDLE cycles, then IDLE.
- **ERROR:** `phy_csn`=1, `error_o`=1. `clear_error` goes to RECOVER.

## Timing
- Request accepted on cycle N; the first CA word is on `phy_dq_o` at N+1.
- 1x latency: the data phase starts at N+4+TACC_COUNT.
- Write data is consumed in the same cycle as the `wr_valid`&`wr_ready` handshake. The `phy_dq_o` and `phy_rwds_o` muxes are combinational.
- Read latency is strobe +1 cycle.
- Back-to-back requests are separated by at least CSN_IDLE+1 cycles of `phy_csn` high.
- A strobe and a timeout expiring in the same cycle: the strobe wins.

## Structure
- **Package `hyperbus_pkg`:**
  - state encodings
  - CA bit-position constants
  - `ca_pack(write, reg_space, adr)` function
  - RWDS strobe constant 2'b01
- **Sub-module `hyperbus_ca_shift`:** 48-bit load/shift register emitting 16-bit CA words.
- `ioddr` instances stay in the parent wrapper.

## Test plan
- **Reset:** hold `rst` 3 cycles, release → `phy_rstn` low for RESET_COUNT+1 cycles, then `req_ready`=1 and `phy_csn`=1.
- **1x read:** `req_adr`=0x0000_0010, len 4, RWDS low in CMD.
  - CA words 0xA000, 0x0002, 0x0000.
  - 4 strobes with data 0x1111–0x4444 → four `rd_valid`, `rd_last` on 0x4444.
- **2x write:** RWDS high in CMD, len 2, `wr_strb`=2'b10.
  - 12 latency cycles, then `phy_rwds_o`=2'b01 on each word.
  - `wr_valid` low on the second word → `phy_rwds_o`=2'b11.
- **Register write:** `req_reg_space`=1, `req_write`=1, data 0x8F1F.
  - WRITE immediately after CMD, `phy_rwds_oe`=0, one word.
- **Read timeout:** no strobe for 32 cycles → `error_o`=1 and `phy_csn`=1.
  - `clear_error` → IDLE after CSN_IDLE cycles.
- **Mid-burst reset:** `rst` during READ word 2 → all outputs at reset values in the same cycle, no `rd_last`.
